// File: rtl/ddr_judge.sv
// Player-side rhythm judge: detects new target arrows and button presses, grades each
// arrow as PERFECT/GOOD/MISS inside a tick-based window, and tracks score and combos.
module ddr_judge #(
    parameter int WINDOW_TICKS  = 300,
    parameter int PERFECT_TICKS = 100,
    parameter int PTS_PERFECT   = 2,
    parameter int PTS_GOOD      = 1,
    parameter int SCORE_W       = 16,
    parameter int COMBO_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               tgt_left,
    input  logic               tgt_right,
    input  logic               tgt_up,
    input  logic               tgt_down,
    input  logic               level_done,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic               hit,
    output logic               perfect,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo,
    output logic [3:0]         pending,
    output logic               finished
);

    localparam int AGE_W = $clog2(WINDOW_TICKS + 1);
    localparam logic [AGE_W-1:0]   AGE_LAST   = AGE_W'(WINDOW_TICKS - 1);
    localparam logic [AGE_W-1:0]   AGE_MAX    = AGE_W'(WINDOW_TICKS);
    localparam logic [AGE_W-1:0]   AGE_PERF   = AGE_W'(PERFECT_TICKS);
    localparam logic [SCORE_W:0]   ADD_PERF   = (SCORE_W + 1)'(PTS_PERFECT);
    localparam logic [SCORE_W:0]   ADD_GOOD   = (SCORE_W + 1)'(PTS_GOOD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         tgt_s, btn_s, arr_s, prs_s;
    logic [3:0]         tgt_prev_q, btn_prev_q;
    logic [3:0]         pending_q, pending_d;
    logic [AGE_W-1:0]   age_q, age_d;
    logic               hit_q, hit_d, perfect_q, perfect_d, miss_q, miss_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d, max_q, max_d;
    logic               finished_q;
    logic [SCORE_W:0]   score_sum_s;
    logic [COMBO_W:0]   combo_sum_s;

    assign tgt_s = {tgt_left, tgt_right, tgt_up, tgt_down};
    assign btn_s = {btn_left, btn_right, btn_up, btn_down};
    assign arr_s = tgt_s & ~tgt_prev_q;
    assign prs_s = btn_s & ~btn_prev_q;

    // Judgement FSM: grade the pending arrow and decide what is pending next
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        age_d     = age_q;
        hit_d     = 1'b0;
        perfect_d = 1'b0;
        miss_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_done) begin
                    state_d = ST_DONE;
                end else if (arr_s != 4'b0000) begin
                    pending_d = arr_s;
                    age_d     = {AGE_W{1'b0}};
                    state_d   = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if ((prs_s != 4'b0000) && (prs_s == pending_q)) begin
                    hit_d     = 1'b1;
                    perfect_d = (age_q < AGE_PERF);
                end else if (prs_s != 4'b0000) begin
                    miss_d = 1'b1;
                end else if (level_done) begin
                    miss_d = 1'b1;
                end else if (tick && (age_q == AGE_LAST)) begin
                    miss_d = 1'b1;
                end else if (arr_s != 4'b0000) begin
                    miss_d = 1'b1;
                end else begin
                    miss_d = 1'b0;
                end

                // A fresh arrow arriving alongside a verdict becomes the next target
                if (level_done) begin
                    state_d   = ST_DONE;
                    pending_d = 4'b0000;
                end else if (hit_d || miss_d) begin
                    if (arr_s != 4'b0000) begin
                        pending_d = arr_s;
                        age_d     = {AGE_W{1'b0}};
                    end else begin
                        pending_d = 4'b0000;
                        state_d   = ST_IDLE;
                    end
                end else if (tick && (age_q != AGE_MAX)) begin
                    age_d = age_q + {{(AGE_W-1){1'b0}}, 1'b1};
                end else begin
                    age_d = age_q;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 4'b0000;
                age_d     = {AGE_W{1'b0}};
            end
        endcase
    end

    // Saturating score and combo bookkeeping for the verdict of this cycle
    always_comb begin
        score_sum_s = {1'b0, score_q} + (perfect_d ? ADD_PERF : ADD_GOOD);
        combo_sum_s = {1'b0, combo_q} + {{COMBO_W{1'b0}}, 1'b1};
        score_d     = score_q;
        combo_d     = combo_q;
        max_d       = max_q;
        if (hit_d) begin
            score_d = score_sum_s[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_s[SCORE_W-1:0];
            combo_d = combo_sum_s[COMBO_W] ? {COMBO_W{1'b1}} : combo_sum_s[COMBO_W-1:0];
            max_d   = (combo_d > max_q) ? combo_d : max_q;
        end else if (miss_d) begin
            combo_d = {COMBO_W{1'b0}};
        end else begin
            combo_d = combo_q;
        end
    end

    // State, history and output registers; history resets high to swallow held inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tgt_prev_q <= 4'b1111;
            btn_prev_q <= 4'b1111;
            pending_q  <= 4'b0000;
            age_q      <= {AGE_W{1'b0}};
            hit_q      <= 1'b0;
            perfect_q  <= 1'b0;
            miss_q     <= 1'b0;
            score_q    <= {SCORE_W{1'b0}};
            combo_q    <= {COMBO_W{1'b0}};
            max_q      <= {COMBO_W{1'b0}};
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_prev_q <= tgt_s;
            btn_prev_q <= btn_s;
            pending_q  <= pending_d;
            age_q      <= age_d;
            hit_q      <= hit_d;
            perfect_q  <= perfect_d;
            miss_q     <= miss_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            max_q      <= max_d;
            finished_q <= (state_d == ST_DONE);
        end
    end

    assign hit       = hit_q;
    assign perfect   = perfect_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_q;
    assign pending   = pending_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_ddr_judge.sv
// Self-checking bench for ddr_judge: directed scenarios plus random traffic compared
// against a rule-level reference model of the judge.
module tb_ddr_judge;

    localparam int WIN  = 300;
    localparam int PERF = 100;

    logic        clk = 1'b0;
    logic        rst, tick, level_done;
    logic [3:0]  tgt, btn;
    logic        hit, perfect, miss, finished;
    logic [15:0] score;
    logic [7:0]  combo, max_combo;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    // reference model state (mode: 0 idle, 1 waiting on an arrow, 2 level over)
    int         m_mode, m_age, m_score, m_combo, m_max;
    logic [3:0] m_pending, m_prev_tgt, m_prev_btn;
    logic       m_hit, m_perf, m_miss;

    ddr_judge dut (
        .clk(clk), .rst(rst), .tick(tick),
        .tgt_left(tgt[3]), .tgt_right(tgt[2]), .tgt_up(tgt[1]), .tgt_down(tgt[0]),
        .level_done(level_done),
        .btn_left(btn[3]), .btn_right(btn[2]), .btn_up(btn[1]), .btn_down(btn[0]),
        .hit(hit), .perfect(perfect), .miss(miss), .score(score), .combo(combo),
        .max_combo(max_combo), .pending(pending), .finished(finished)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [3:0] arr, prs;
        int verdict;
        arr = tgt & ~m_prev_tgt;
        prs = btn & ~m_prev_btn;
        m_prev_tgt = tgt;
        m_prev_btn = btn;
        m_hit = 1'b0; m_perf = 1'b0; m_miss = 1'b0;
        verdict = 0;
        if (rst) begin
            m_mode = 0; m_age = 0; m_score = 0; m_combo = 0; m_max = 0;
            m_pending = 4'h0; m_prev_tgt = 4'hF; m_prev_btn = 4'hF;
        end else if (m_mode == 0) begin
            if (level_done) m_mode = 2;
            else if (arr != 0) begin m_pending = arr; m_age = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (prs != 0 && prs == m_pending) verdict = 1;
            else if (prs != 0 || level_done || (tick && m_age == WIN - 1) || arr != 0) verdict = 2;
            if (verdict == 1) begin
                m_hit = 1'b1;
                m_perf = (m_age < PERF);
                m_score = m_score + (m_perf ? 2 : 1);
                if (m_score > 65535) m_score = 65535;
                m_combo = (m_combo < 255) ? m_combo + 1 : 255;
                if (m_combo > m_max) m_max = m_combo;
            end
            if (verdict == 2) begin m_miss = 1'b1; m_combo = 0; end
            if (level_done) begin m_mode = 2; m_pending = 4'h0; end
            else if (verdict != 0) begin
                if (arr != 0) begin m_pending = arr; m_age = 0; end
                else begin m_pending = 4'h0; m_mode = 0; end
            end else if (tick && m_age < WIN) m_age++;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cycle();
            tick = 1'b0; cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; level_done = 1'b0; tgt = 4'h0; btn = 4'h0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        checks++;
        if ({hit, perfect, miss, finished, pending, score, combo, max_combo} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {hit, perfect, miss, finished, pending, score, combo, max_combo});
        end
    endtask

    task automatic test_hold_reset();
        rst = 1'b1; tgt = 4'b0010; btn = 4'b0010;
        cycle();
        rst = 1'b0;
        cycle(); cycle();
        checks++;
        if (pending !== 4'h0 || hit !== 1'b0 || miss !== 1'b0) begin
            errors++;
            $display("FAIL hold_reset pending=%b hit=%b miss=%b required 0000/0/0", pending, hit, miss);
        end
        tgt = 4'h0; btn = 4'h0;
        cycle();
    endtask

    task automatic test_perfect();
        tgt = 4'b0010; cycle();
        checks++;
        if (pending !== 4'b0010) begin
            errors++; $display("FAIL perfect_pending got %b required 0010", pending);
        end
        tgt = 4'h0; ticks(50);
        btn = 4'b0010; cycle();
        checks++;
        if (hit !== 1'b1 || perfect !== 1'b1 || score !== 16'd2 || combo !== 8'd1) begin
            errors++;
            $display("FAIL perfect_hit hit=%b perf=%b score=%0d combo=%0d required 1 1 2 1",
                     hit, perfect, score, combo);
        end
        btn = 4'h0; cycle();
        checks++;
        if (hit !== 1'b0 || perfect !== 1'b0 || pending !== 4'h0) begin
            errors++; $display("FAIL perfect_pulse hit=%b perf=%b pending=%b required 0 0 0000",
                               hit, perfect, pending);
        end
    endtask

    task automatic test_good();
        tgt = 4'b1000; cycle();
        tgt = 4'h0; ticks(200);
        btn = 4'b1000; cycle();
        checks++;
        if (hit !== 1'b1 || perfect !== 1'b0 || score !== 16'd3 || combo !== 8'd2) begin
            errors++;
            $display("FAIL good_hit hit=%b perf=%b score=%0d combo=%0d required 1 0 3 2",
                     hit, perfect, score, combo);
        end
        btn = 4'h0; cycle();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        tgt = 4'b0100; cycle();
        tgt = 4'h0;
        for (int i = 1; i <= 320; i++) begin
            tick = 1'b1; cycle();
            tick = 1'b0;
            if (miss === 1'b1) begin n = i; break; end
            cycle();
        end
        checks++;
        if (n != 300) begin
            errors++; $display("FAIL timeout_tick miss at tick %0d required 300 (0 = never)", n);
        end
        checks++;
        if (combo !== 8'd0 || pending !== 4'h0 || score !== 16'd3 || max_combo !== 8'd2) begin
            errors++;
            $display("FAIL timeout_state combo=%0d pending=%b score=%0d max=%0d required 0 0000 3 2",
                     combo, pending, score, max_combo);
        end
        cycle();
    endtask

    task automatic test_wrong_button();
        tgt = 4'b0001; cycle();
        tgt = 4'h0; ticks(10);
        btn = 4'b1000; cycle();
        checks++;
        if (miss !== 1'b1 || hit !== 1'b0) begin
            errors++; $display("FAIL wrong_btn miss=%b hit=%b required 1 0", miss, hit);
        end
        btn = 4'h0; cycle();
        btn = 4'b0001; cycle();
        checks++;
        if (miss !== 1'b0 || hit !== 1'b0 || score !== 16'd3) begin
            errors++; $display("FAIL idle_press miss=%b hit=%b score=%0d required 0 0 3", miss, hit, score);
        end
        btn = 4'h0; cycle();
    endtask

    task automatic test_replace();
        tgt = 4'b1000; cycle();
        tgt = 4'h0; ticks(100);
        tgt = 4'b0010; cycle();
        checks++;
        if (miss !== 1'b1 || pending !== 4'b0010) begin
            errors++; $display("FAIL replace_miss miss=%b pending=%b required 1 0010", miss, pending);
        end
        tgt = 4'h0; ticks(20);
        btn = 4'b0010; cycle();
        checks++;
        if (hit !== 1'b1 || perfect !== 1'b1 || score !== 16'd5) begin
            errors++; $display("FAIL replace_hit hit=%b perf=%b score=%0d required 1 1 5",
                               hit, perfect, score);
        end
        btn = 4'h0; cycle();
    endtask

    task automatic test_combo_done();
        for (int i = 0; i < 4; i++) begin
            tgt = 4'b0001; cycle();
            tgt = 4'h0; btn = 4'b0001; cycle();
            btn = 4'h0; cycle();
        end
        checks++;
        if (combo !== 8'd5 || max_combo !== 8'd5 || score !== 16'd13) begin
            errors++; $display("FAIL combo_build combo=%0d max=%0d score=%0d required 5 5 13",
                               combo, max_combo, score);
        end
        tgt = 4'b0100; cycle();
        tgt = 4'h0; btn = 4'b1000; cycle();
        checks++;
        if (miss !== 1'b1 || combo !== 8'd0 || max_combo !== 8'd5) begin
            errors++; $display("FAIL combo_break miss=%b combo=%0d max=%0d required 1 0 5",
                               miss, combo, max_combo);
        end
        btn = 4'h0; tgt = 4'b0010; cycle();
        tgt = 4'h0; level_done = 1'b1; cycle();
        checks++;
        if (miss !== 1'b1 || finished !== 1'b1 || score !== 16'd13) begin
            errors++; $display("FAIL done_miss miss=%b finished=%b score=%0d required 1 1 13",
                               miss, finished, score);
        end
        level_done = 1'b0; tgt = 4'b1000; cycle();
        btn = 4'b1000; tick = 1'b1; cycle();
        tick = 1'b0; cycle();
        checks++;
        if (hit !== 1'b0 || miss !== 1'b0 || score !== 16'd13 || finished !== 1'b1 || max_combo !== 8'd5) begin
            errors++; $display("FAIL done_hold hit=%b miss=%b score=%0d fin=%b max=%0d required 0 0 13 1 5",
                               hit, miss, score, finished, max_combo);
        end
        rst = 1'b1; cycle();
        rst = 1'b0; tgt = 4'h0; btn = 4'h0; cycle();
        checks++;
        if ({hit, perfect, miss, finished, pending, score, combo, max_combo} !== 40'd0) begin
            errors++; $display("FAIL done_reset got %h required 0",
                               {hit, perfect, miss, finished, pending, score, combo, max_combo});
        end
    endtask

    task automatic test_random();
        logic [39:0] exp_v;
        int bad;
        bad = 0;
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 300 == 0);
            tick = ($urandom % 3 == 0);
            level_done = ($urandom % 400 == 0);
            if ($urandom % 6 == 0) tgt = 4'($urandom);
            case ($urandom % 8)
                0: btn = 4'($urandom);
                1: btn = m_pending;
                2: btn = 4'h0;
                default: btn = btn;
            endcase
            cycle();
            exp_v = {m_hit, m_perf, m_miss, (m_mode == 2), m_pending,
                     16'(m_score), 8'(m_combo), 8'(m_max)};
            checks++;
            if ({hit, perfect, miss, finished, pending, score, combo, max_combo} !== exp_v) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d got %h required %h", i,
                             {hit, perfect, miss, finished, pending, score, combo, max_combo}, exp_v);
                bad++;
            end
        end
        rst = 1'b0; tick = 1'b0; level_done = 1'b0;
    endtask

    task automatic test_saturate();
        rst = 1'b1; tgt = 4'h0; btn = 4'h0; cycle();
        rst = 1'b0;
        for (int i = 0; i < 32800; i++) begin
            tgt = 4'b0001; btn = 4'h0; cycle();
            tgt = 4'h0; btn = 4'b0001; cycle();
        end
        checks++;
        if (score !== 16'hFFFF || combo !== 8'hFF || max_combo !== 8'hFF) begin
            errors++; $display("FAIL saturate score=%h combo=%h max=%h required FFFF FF FF",
                               score, combo, max_combo);
        end
        checks++;
        if (score !== 16'(m_score) || hit !== m_hit) begin
            errors++; $display("FAIL saturate_model score=%h hit=%b required %h %b",
                               score, hit, 16'(m_score), m_hit);
        end
    endtask

    initial begin
        test_reset();
        test_hold_reset();
        test_perfect();
        test_good();
        test_timeout();
        test_wrong_button();
        test_replace();
        test_combo_done();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
